ddr3_dma_arbiter: RTL and testbench

- Two-requester Avalon-MM burst arbiter in front of the FPGA-side DDR3 controller port of soc_system.
- Two DMA engines share the single DDR3 master: channel 0 is the read DMA, channel 1 is the write DMA.
- Grants at burst granularity, round-robin between channels.
- A tag FIFO tracks outstanding read bursts so returning readdatavalid beats are steered to the channel that issued them.

---
 rtl/ddr3_dma_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_ddr3_dma_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dma_arbiter.sv
// ddr3_dma_arbiter: two-channel Avalon-MM burst arbiter for the DDR3 port.
//   Channel 0 = read DMA, channel 1 = write DMA. Grants are held for a whole
//   burst. Outstanding read bursts are tracked in a tag FIFO so returning
//   readdatavalid beats reach the channel that issued them.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   c0_*/c1_*             Avalon-MM slave side of each requester
//   m_*                   Avalon-MM master to the DDR3 controller
//   busy                  arbiter in a burst or reads still outstanding
// Build option:
//   DDR3_DMA_ARB_FIXED_PRIO_EN  defined: channel 0 wins every contested
//                               arbitration (no round-robin pointer).
module ddr3_dma_arbiter #(
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned RD_TAGS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     c0_address,
  input  logic                  c0_read,
  input  logic                  c0_write,
  input  logic [BURST_W-1:0]    c0_burstcount,
  input  logic [DATA_W-1:0]     c0_writedata,
  input  logic [DATA_W/8-1:0]   c0_byteenable,
  output logic                  c0_waitrequest,
  output logic [DATA_W-1:0]     c0_readdata,
  output logic                  c0_readdatavalid,
  input  logic [ADDR_W-1:0]     c1_address,
  input  logic                  c1_read,
  input  logic                  c1_write,
  input  logic [BURST_W-1:0]    c1_burstcount,
  input  logic [DATA_W-1:0]     c1_writedata,
  input  logic [DATA_W/8-1:0]   c1_byteenable,
  output logic                  c1_waitrequest,
  output logic [DATA_W-1:0]     c1_readdata,
  output logic                  c1_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [BURST_W-1:0]    m_burstcount,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  output logic                  busy
);

  localparam int unsigned PTR_W = $clog2(RD_TAGS);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_RD_CMD} state_t;

  state_t              r_state;
  logic                r_gnt;
`ifndef DDR3_DMA_ARB_FIXED_PRIO_EN
  logic                r_rr;
`endif
  logic [BURST_W-1:0]  r_wr_cnt;
  logic [BURST_W-1:0]  r_wr_bc;
  logic [BURST_W-1:0]  r_rd_cnt;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_tag_ch [RD_TAGS];
  logic [BURST_W-1:0]  r_tag_bc [RD_TAGS];

  logic                w_tag_full;
  logic                w_tag_empty;
  logic                w_req0;
  logic                w_req1;
  logic                w_any_req;
  logic                w_win;
  logic                w_win_write;
  logic [BURST_W-1:0]  w_win_bc;
  logic                w_sel_read;
  logic                w_sel_write;
  logic                w_granted;
  logic                w_push;
  logic                w_wr_acc;
  logic                w_wr_last;
  logic                w_rd_beat;
  logic                w_head_ch;
  logic                w_pop;

  assign w_tag_full  = (r_count == CNT_W'(RD_TAGS));
  assign w_tag_empty = (r_count == '0);

  // Eligibility: a read needs a free tag slot, a write never waits on tags.
  assign w_req0    = c0_write | (c0_read & ~w_tag_full);
  assign w_req1    = c1_write | (c1_read & ~w_tag_full);
  assign w_any_req = w_req0 | w_req1;

`ifdef DDR3_DMA_ARB_FIXED_PRIO_EN
  assign w_win = ~w_req0;
`else
  assign w_win = (w_req0 & w_req1) ? r_rr : w_req1;
`endif

  assign w_win_write = w_win ? c1_write : c0_write;
  assign w_win_bc    = w_win ? c1_burstcount : c0_burstcount;

  // Master side follows the granted channel combinationally.
  assign w_sel_read   = r_gnt ? c1_read : c0_read;
  assign w_sel_write  = r_gnt ? c1_write : c0_write;
  assign m_address    = r_gnt ? c1_address : c0_address;
  assign m_burstcount = r_gnt ? c1_burstcount : c0_burstcount;
  assign m_writedata  = r_gnt ? c1_writedata : c0_writedata;
  assign m_byteenable = r_gnt ? c1_byteenable : c0_byteenable;
  assign m_read       = (r_state == S_RD_CMD) & w_sel_read;
  assign m_write      = (r_state == S_WR_BURST) & w_sel_write;

  assign w_granted      = (r_state != S_IDLE);
  assign c0_waitrequest = (w_granted & ~r_gnt) ? m_waitrequest : 1'b1;
  assign c1_waitrequest = (w_granted &  r_gnt) ? m_waitrequest : 1'b1;

  assign w_push    = m_read & ~m_waitrequest;
  assign w_wr_acc  = m_write & ~m_waitrequest;
  assign w_wr_last = ((r_wr_cnt + BURST_W'(1)) == r_wr_bc);

  // Read return steering by the head tag; beats with no tag are dropped.
  assign w_rd_beat        = m_readdatavalid & ~w_tag_empty;
  assign w_head_ch        = r_tag_ch[r_rptr];
  assign w_pop            = w_rd_beat & ((r_rd_cnt + BURST_W'(1)) == r_tag_bc[r_rptr]);
  assign c0_readdatavalid = w_rd_beat & ~w_head_ch;
  assign c1_readdatavalid = w_rd_beat &  w_head_ch;
  assign c0_readdata      = m_readdata;
  assign c1_readdata      = m_readdata;

  assign busy = w_granted | ~w_tag_empty;

  // Arbitration FSM, burst counters and tag FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= 1'b0;
`ifndef DDR3_DMA_ARB_FIXED_PRIO_EN
      r_rr     <= 1'b0;
`endif
      r_wr_cnt <= '0;
      r_wr_bc  <= '0;
      r_rd_cnt <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_win;
            r_wr_bc <= w_win_bc;
            r_state <= w_win_write ? S_WR_BURST : S_RD_CMD;
          end
        end
        S_RD_CMD: begin
          if (w_push) begin
`ifndef DDR3_DMA_ARB_FIXED_PRIO_EN
            r_rr    <= ~r_gnt;
`endif
            r_state <= S_IDLE;
          end
        end
        S_WR_BURST: begin
          if (w_wr_acc) begin
            if (w_wr_last) begin
              r_wr_cnt <= '0;
`ifndef DDR3_DMA_ARB_FIXED_PRIO_EN
              r_rr     <= ~r_gnt;
`endif
              r_state  <= S_IDLE;
            end else begin
              r_wr_cnt <= r_wr_cnt + BURST_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end

      if (w_rd_beat) begin
        if (w_pop) begin
          r_rd_cnt <= '0;
          r_rptr   <= r_rptr + PTR_W'(1);
        end else begin
          r_rd_cnt <= r_rd_cnt + BURST_W'(1);
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_ch[r_wptr] <= r_gnt;
      r_tag_bc[r_wptr] <= m_burstcount;
    end
  end

endmodule

// File: tb/tb_ddr3_dma_arbiter.sv
// Directed bench for ddr3_dma_arbiter: vector table for a single read burst,
// hand sequences for write stalls, contention, tag-full, interleaved return
// and reset in the middle of a burst.
module tb_ddr3_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] c0_address, c1_address, m_address;
  logic        c0_read, c1_read, c0_write, c1_write;
  logic [3:0]  c0_burstcount, c1_burstcount, m_burstcount;
  logic [63:0] c0_writedata, c1_writedata, m_writedata;
  logic [7:0]  c0_byteenable, c1_byteenable, m_byteenable;
  logic        c0_waitrequest, c1_waitrequest;
  logic [63:0] c0_readdata, c1_readdata, m_readdata;
  logic        c0_readdatavalid, c1_readdatavalid;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr3_dma_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_address(c0_address), .c0_read(c0_read), .c0_write(c0_write),
    .c0_burstcount(c0_burstcount), .c0_writedata(c0_writedata),
    .c0_byteenable(c0_byteenable), .c0_waitrequest(c0_waitrequest),
    .c0_readdata(c0_readdata), .c0_readdatavalid(c0_readdatavalid),
    .c1_address(c1_address), .c1_read(c1_read), .c1_write(c1_write),
    .c1_burstcount(c1_burstcount), .c1_writedata(c1_writedata),
    .c1_byteenable(c1_byteenable), .c1_waitrequest(c1_waitrequest),
    .c1_readdata(c1_readdata), .c1_readdatavalid(c1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .busy(busy)
  );

  typedef struct {
    logic       c0_rd;
    logic       m_wait;
    logic       m_rdv;
    logic [6:0] exp;      // {m_read, m_write, c0_wait, c1_wait, c0_rdv, c1_rdv, busy}
    logic       addr_chk;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wdat(input int i);
    return {32'hC1DA_7A00 + 32'(i), 32'h5A5A_0000 | 32'(i)};
  endfunction

  function automatic logic [6:0] outv();
    return {m_read, m_write, c0_waitrequest, c1_waitrequest,
            c0_readdatavalid, c1_readdatavalid, busy};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
    c0_address = '0; c1_address = '0; c0_burstcount = 4'd1; c1_burstcount = 4'd1;
    c0_writedata = '0; c1_writedata = '0; c0_byteenable = 8'hFF; c1_byteenable = 8'hFF;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_state", 64'(outv()), 64'(7'b0011000));
    tick();
    reset = 1'b0;
  endtask

  // Holds a read request on one channel until the master accepts it.
  task automatic issue_read(input int ch, input logic [26:0] addr, input logic [3:0] bc);
    bit ok = 0;
    if (ch == 0) begin c0_read = 1; c0_address = addr; c0_burstcount = bc; end
    else         begin c1_read = 1; c1_address = addr; c1_burstcount = bc; end
    for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
      @(negedge clk);
      if (m_read && !m_waitrequest) ok = 1;
      tick();
    end
    c0_read = 0; c1_read = 0;
    chk("issue_read_accepted", 64'(ok), 64'd1);
  endtask

  // Stimulus legality and dropped-beat monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if ((c0_read && c0_write) || (c1_read && c1_write)) begin
        errors++;
        $display("FAIL illegal_rd_wr got=1 exp=0");
      end
      if (((c0_read || c0_write) && c0_burstcount == 0) ||
          ((c1_read || c1_write) && c1_burstcount == 0)) begin
        errors++;
        $display("FAIL illegal_burst0 got=0 exp=nonzero");
      end
      if (m_readdatavalid && !c0_readdatavalid && !c1_readdatavalid) begin
        errors++;
        $display("FAIL dropped_beat got=0 exp=1");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc, widx, c0_low, ng, pushes, rd_acc, wr_acc, nr, wacc;
    bit  done, seen;
    logic order [4];
    logic exp_ord [4];
    int  route [5];

    vecs[0] = '{1'b1, 1'b0, 1'b0, 7'b0011000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 7'b1001001, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 7'b0011001, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 7'b0011101, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 7'b0011101, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 7'b0011101, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 7'b0011101, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 7'b0011000, 1'b0};

    // Single read, table-driven
    do_reset();
    c0_address = 27'h100; c0_burstcount = 4'd4;
    for (int i = 0; i < 8; i++) begin
      c0_read = vecs[i].c0_rd;
      m_waitrequest = vecs[i].m_wait;
      m_readdatavalid = vecs[i].m_rdv;
      @(negedge clk);
      chk($sformatf("single_read_row%0d", i), 64'(outv()), 64'(vecs[i].exp));
      if (vecs[i].addr_chk) chk("single_read_addr", 64'(m_address), 64'h100);
      tick();
    end

    // Write burst with stalls; c0 read held meanwhile
    do_reset();
    c1_burstcount = 4'd8; c0_address = 27'h2A0; c0_burstcount = 4'd2;
    acc = 0; widx = 0; c0_low = 0; done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      m_waitrequest = (cyc % 2 == 1);
      c1_write = (widx < 8);
      c1_writedata = wdat(widx);
      c0_read = (cyc >= 1);
      @(negedge clk);
      if (!c0_waitrequest) c0_low++;
      if (m_write && !m_waitrequest) begin
        chk($sformatf("wr_data%0d", acc), m_writedata, wdat(acc));
        acc++;
      end
      if (c1_write && !c1_waitrequest) widx++;
      if (acc == 8) done = 1;
      tick();
    end
    chk("wr_beats", 64'(acc), 64'd8);
    chk("c0_stalled_during_wr", 64'(c0_low), 64'd0);
    c1_write = 0; m_waitrequest = 0;
    @(negedge clk);
    chk("post_wr_idle", 64'({m_read, m_write}), 64'd0);
    tick();
    @(negedge clk);
    chk("post_wr_c0_grant", 64'({m_read, c0_waitrequest, c1_waitrequest}), 64'(3'b101));
    chk("post_wr_c0_addr", 64'(m_address), 64'h2A0);
    tick();
    c0_read = 0;

    // Contention, burst 2 reads from both channels
    do_reset();
`ifdef DDR3_DMA_ARB_FIXED_PRIO_EN
    exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0; exp_ord[3] = 0;
`else
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
`endif
    c0_read = 1; c1_read = 1; c0_burstcount = 4'd2; c1_burstcount = 4'd2;
    c0_address = 27'h10; c1_address = 27'h20;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      @(negedge clk);
      if (m_read && !m_waitrequest) begin
        order[ng] = c0_waitrequest ? 1'b1 : 1'b0;
        ng++;
      end
      tick();
    end
    c0_read = 0; c1_read = 0;
    chk("contention_grants", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < ng) chk($sformatf("contention_order%0d", i), 64'(order[i]), 64'(exp_ord[i]));

    // Tag FIFO full
    do_reset();
    c0_read = 1; c0_burstcount = 4'd1; pushes = 0;
    for (int cyc = 0; cyc < 40 && pushes < 8; cyc++) begin
      @(negedge clk);
      if (m_read && !m_waitrequest) pushes++;
      tick();
    end
    chk("tag_fill", 64'(pushes), 64'd8);
    c1_write = 1; c1_burstcount = 4'd2; rd_acc = 0; wr_acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (m_read && !m_waitrequest) rd_acc++;
      if (m_write && !m_waitrequest) wr_acc++;
      tick();
    end
    chk("full_no_read", 64'(rd_acc), 64'd0);
    chk("full_writes_go", 64'(wr_acc), 64'd8);
    c1_write = 0; m_readdatavalid = 1;
    @(negedge clk);
    chk("full_rdv_c0", 64'({c0_readdatavalid, c1_readdatavalid}), 64'(2'b10));
    tick();
    m_readdatavalid = 0; seen = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (m_read && !m_waitrequest) seen = 1;
      tick();
    end
    chk("ninth_read_issued", 64'(seen), 64'd1);
    c0_read = 0;

    // Interleaved return with a concurrent write burst
    do_reset();
    issue_read(0, 27'h300, 4'd3);
    issue_read(1, 27'h400, 4'd2);
    c1_burstcount = 4'd4; nr = 0; wacc = 0;
    for (int cyc = 0; cyc < 30 && (nr < 5 || wacc < 4); cyc++) begin
      m_readdatavalid = (nr < 5);
      m_readdata = 64'hD00 + 64'(nr);
      c1_write = (wacc < 4);
      c1_writedata = wdat(wacc);
      @(negedge clk);
      if (m_readdatavalid) begin
        route[nr] = c0_readdatavalid ? 0 : (c1_readdatavalid ? 1 : 2);
        if (nr == 3) chk("rd_broadcast", c0_readdata, 64'hD03);
        nr++;
      end
      if (m_write && !m_waitrequest) wacc++;
      tick();
    end
    m_readdatavalid = 0; c1_write = 0;
    chk("interleave_beats", 64'(nr), 64'd5);
    chk("interleave_writes", 64'(wacc), 64'd4);
    for (int i = 0; i < 5; i++)
      if (i < nr) chk($sformatf("route%0d", i), 64'(route[i]), (i < 3) ? 64'd0 : 64'd1);

    // Reset during the 3rd beat of a burst-8 write
    do_reset();
    issue_read(0, 27'h500, 4'd1);
    c1_write = 1; c1_burstcount = 4'd8; acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
      @(negedge clk);
      if (m_write && !m_waitrequest) acc++;
      tick();
    end
    reset = 1;
    @(negedge clk);
    chk("rst_third_beat_on_bus", 64'(m_write), 64'd1);
    tick();
    @(negedge clk);
    chk("rst_mid_burst", 64'(outv()), 64'(7'b0011000));
    tick();
    reset = 0; c1_write = 0;
    c0_read = 1; c1_read = 1; c0_burstcount = 4'd1; c1_burstcount = 4'd1;
    seen = 0; ng = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (m_read && !m_waitrequest) begin
        seen = 1;
        ng = c0_waitrequest ? 1 : 0;
      end
      tick();
    end
    c0_read = 0; c1_read = 0;
    chk("rst_regrant_seen", 64'(seen), 64'd1);
    chk("rst_rr_ptr0", 64'(ng), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
